// File: rtl/temp_history_reader.sv
// rtl/temp_history_reader.sv - streams the temperature sample ring oldest-to-newest over valid/ready
module temp_history_reader #(
  parameter int DEPTH = 10,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] wr_ptr,
  input  logic [AW:0]   fill_count,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [AW:0]   DEPTH_N   = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] DEPTH_W   = (AW+2)'(DEPTH);
  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] ptr;
  logic [AW:0]   remaining;
  logic [AW:0]   snap_n;
  logic [AW+1:0] snap_sum;
  logic [AW-1:0] snap_ptr;
  logic          handshake;
  logic          kill;
  logic          launch;

  // Oldest sample sits n slots behind the writer, modulo the ring length.
  always_comb begin
    snap_n   = (fill_count > DEPTH_N) ? DEPTH_N : fill_count;
    snap_sum = {2'b00, wr_ptr} + DEPTH_W - {1'b0, snap_n};
    snap_ptr = AW'((snap_sum >= DEPTH_W) ? snap_sum - DEPTH_W : snap_sum);
  end

  assign handshake = (state == S_PRESENT) && out_valid && out_ready;
  assign kill      = abort && (state != S_IDLE);
  assign launch    = (state == S_IDLE) && start && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (launch) state_nxt = (snap_n == '0) ? S_DONE : S_ISSUE;
      S_ISSUE:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_PRESENT;
      S_PRESENT: if (handshake) state_nxt = out_last ? S_DONE : S_ISSUE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (kill) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (launch) begin
            ptr       <= snap_ptr;
            remaining <= snap_n;
          end
        end
        S_CAPTURE: begin
          out_data  <= rd_data;
          out_valid <= 1'b1;
          out_last  <= (remaining == (AW+1)'(1));
        end
        S_PRESENT: begin
          if (handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            remaining <= remaining - 1'b1;
            ptr       <= (ptr == LAST_SLOT) ? '0 : ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en   = (state == S_ISSUE);
  assign rd_addr = (state == S_ISSUE) ? ptr : '0;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_temp_history_reader.sv
// tb/tb_temp_history_reader.sv - directed bench with a ring-buffer reference model
module tb_temp_history_reader;
  localparam int DEPTH = 10;
  localparam int AW    = 4;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, out_ready;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   fill_count;
  logic          rd_en, out_valid, out_last, busy, done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, out_data;

  temp_history_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .wr_ptr(wr_ptr), .fill_count(fill_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:15];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: the list of samples a dump must produce, in order.
  int m_exp[$];
  int m_n, m_base, idx;
  bit m_active = 0;
  int rx[$];
  int rx_last[$];
  int done_cnt = 0, rd_en_cnt = 0, busy_cnt = 0, valid_cnt = 0, max_addr = 0;

  task automatic model_start(input int wp, input int fc);
    m_n    = (fc > DEPTH) ? DEPTH : fc;
    m_base = (wp + DEPTH - m_n) % DEPTH;
    m_exp.delete();
    for (int k = 0; k < m_n; k++) m_exp.push_back(ram[(m_base + k) % DEPTH]);
    idx = 0;
    rx.delete();
    rx_last.delete();
    m_active = 1;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        rx.push_back(out_data);
        rx_last.push_back(out_last);
        idx++;
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (out_valid) valid_cnt++;
      if (rd_en) begin
        rd_en_cnt++;
        if (rd_addr > max_addr) max_addr = rd_addr;
      end
    end
  end

  bit         p_hold = 0;
  logic [7:0] p_data;
  logic       p_last;
  always @(negedge clk) begin
    if (!rst) begin
      chk("one_outstanding", rd_en & out_valid, 0);
      if (rd_en) chk("rd_addr_range", rd_addr < DEPTH, 1);
      if (m_active && rd_en && idx < m_n) chk("rd_addr", rd_addr, (m_base + idx) % DEPTH);
      if (m_active && out_valid && idx < m_n) begin
        chk("out_data", out_data, m_exp[idx]);
        chk("out_last", out_last, idx == m_n - 1);
      end
      if (p_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, p_data);
        chk("hold_last", out_last, p_last);
      end
    end
    p_hold = !rst && out_valid && !out_ready && !abort;
    p_data = out_data;
    p_last = out_last;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_dump(output int cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  int cyc, b0, r0, v0, d0, lasts, guard;
  int e_full [10] = '{23, 24, 25, 26, 27, 28, 29, 20, 21, 22};
  int e_part [4]  = '{50, 51, 52, 53};

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'(20 + i);
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    wr_ptr = '0; fill_count = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    rst = 1'b0;
    tick();

    // full buffer, wrap
    wr_ptr = 3; fill_count = 10;
    model_start(3, 10);
    run_dump(cyc);
    chk("full_latency", cyc, 31);
    chk("full_count", rx.size(), 10);
    lasts = 0;
    for (int i = 0; i < rx.size() && i < 10; i++) begin
      chk("full_seq", rx[i], e_full[i]);
      lasts += rx_last[i];
    end
    chk("full_lasts", lasts, 1);
    chk("full_last_pos", rx_last[rx.size()-1], 1);
    m_active = 0;
    tick();

    // partial fill
    for (int i = 0; i < 4; i++) ram[i] = 8'(50 + i);
    max_addr = 0;
    wr_ptr = 4; fill_count = 4;
    model_start(4, 4);
    run_dump(cyc);
    chk("part_latency", cyc, 13);
    chk("part_count", rx.size(), 4);
    for (int i = 0; i < rx.size() && i < 4; i++) chk("part_seq", rx[i], e_part[i]);
    chk("part_last", rx_last[3], 1);
    chk("part_max_addr", max_addr, 3);
    m_active = 0;
    for (int i = 0; i < 4; i++) ram[i] = 8'(20 + i);
    tick();

    // empty
    wr_ptr = 5; fill_count = 0;
    model_start(5, 0);
    b0 = busy_cnt; r0 = rd_en_cnt; v0 = valid_cnt;
    run_dump(cyc);
    chk("empty_latency", cyc, 1);
    tick();
    chk("empty_busy_cycles", busy_cnt - b0, 1);
    chk("empty_rd_en", rd_en_cnt - r0, 0);
    chk("empty_valid", valid_cnt - v0, 0);
    m_active = 0;

    // backpressure
    wr_ptr = 3; fill_count = 3; out_ready = 1'b0;
    model_start(3, 3);
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin tick(); guard++; end
    chk("bp_valid_seen", out_valid, 1);
    r0 = rd_en_cnt;
    repeat (5) tick();
    chk("bp_no_rd_en", rd_en_cnt - r0, 0);
    chk("bp_still_valid", out_valid, 1);
    chk("bp_data", out_data, 20);
    out_ready = 1'b1;
    guard = 0;
    while (!done && guard < 50) begin tick(); guard++; end
    chk("bp_done", done, 1);
    chk("bp_count", rx.size(), 3);
    chk("bp_seq0", rx[0], 20);
    chk("bp_seq2", rx[2], 22);
    m_active = 0;
    tick();

    // abort on the second PRESENT, with an ignored start while busy
    wr_ptr = 3; fill_count = 10;
    model_start(3, 10);
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (!(out_valid && rx.size() == 1) && guard < 30) begin tick(); guard++; end
    chk("abort_reach", rx.size(), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_last", out_last, 0);
    m_active = 0;
    repeat (8) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_count", rx.size(), 2);
    chk("abort_seq1", rx[1], 24);

    // start with abort in IDLE is dropped
    r0 = rd_en_cnt;
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    tick();
    chk("start_abort_rd", rd_en_cnt - r0, 0);

    // reset in CAPTURE, then replay with fill_count above DEPTH
    wr_ptr = 3; fill_count = 10;
    model_start(3, 10);
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (!(rd_en && rx.size() == 1) && guard < 30) begin tick(); guard++; end
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_last", out_last, 0);
    chk("mrst_rd_en", rd_en, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    m_active = 0;
    tick();
    rst = 1'b0;
    tick();
    wr_ptr = 3; fill_count = 15;
    model_start(3, 15);
    run_dump(cyc);
    chk("replay_latency", cyc, 31);
    chk("replay_count", rx.size(), 10);
    chk("replay_first", rx[0], 23);
    chk("replay_final", rx[rx.size()-1], 22);
    m_active = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/temp_history_reader.md
Name: temp_history_reader

Overview:
- Read side of the temperature sample buffer.
- The buffer writer fills a DEPTH-entry circular RAM and exports its write pointer and fill count.
- On a dump request, this block walks the RAM from oldest to newest sample and streams each 8-bit sample to a downstream consumer (UART formatter / display sequencer) over a valid/ready handshake.
- The block owns no sample storage; it drives the RAM read port only.

Parameters:
DEPTH, 10, number of sample slots in the circular RAM
AW, 4, RAM address width; must satisfy 2^AW >= DEPTH
DW, 8, sample width in bits

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  single-cycle dump request; honoured only in IDLE
abort  input  1  cancel an in-progress dump
wr_ptr  input  AW  writer's next write slot (0..DEPTH-1)
fill_count  input  AW+1  number of valid samples held (0..DEPTH)
rd_en  output  1  RAM read strobe
rd_addr  output  AW  RAM read address
rd_data  input  DW  RAM read data; valid exactly one cycle after rd_en
out_data  output  DW  streamed sample
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_last  output  1  marks the final sample of a dump
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a dump completes normally

Behaviour:
- Reset (async, any state): state=IDLE. rd_en=0, rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0. Internal pointer and count cleared.
- FSM states: IDLE, ISSUE, CAPTURE, PRESENT, DONE.
- IDLE, start=1:
  - snapshot n = min(fill_count, DEPTH).
  - snapshot ptr = (wr_ptr + DEPTH - n) mod DEPTH (oldest sample).
  - remaining = n.
  - If n=0 -> DONE; otherwise -> ISSUE.
- IDLE, start=0: remain in IDLE. start in any other state is ignored.
- ISSUE: rd_en=1, rd_addr=ptr for exactly one cycle -> CAPTURE.
- CAPTURE:
  - out_data <= rd_data.
  - out_valid <= 1.
  - out_last <= (remaining==1).
  - -> PRESENT.
- PRESENT:
  - out_data, out_valid, out_last held stable until out_valid && out_ready.
  - On handshake: out_valid <= 0, out_last <= 0, remaining decrements, ptr <= (ptr==DEPTH-1) ? 0 : ptr+1.
  - After handshake: -> DONE if the transferred sample was last, else -> ISSUE.
- DONE: done=1 for one cycle -> IDLE.
- Latency and throughput:
  - Start-to-first out_valid: 3 cycles (IDLE->ISSUE->CAPTURE->PRESENT).
  - With out_ready tied high: one sample per 3 cycles.
  - Total dump of n samples: 3n+1 cycles from start to done.
- Wrap-around: the pointer wraps at DEPTH, not at 2^AW. rd_addr is never >= DEPTH.
- fill_count > DEPTH is treated as DEPTH. wr_ptr >= DEPTH is out of contract.
- Writer activity during a dump:
  - The snapshot fixes both order and count.
  - The writer may overwrite slots not yet read; the block streams whatever the RAM returns.
  - No retry or consistency check.
- abort=1 in any non-IDLE state:
  - next cycle: IDLE, out_valid=0, out_last=0, rd_en=0, no done pulse.
  - Abort takes priority over a same-cycle handshake; that sample counts as accepted by the consumer but the dump ends.
- start and abort asserted together in IDLE: abort wins, the block stays in IDLE.
- rd_en is asserted only in ISSUE. At most one outstanding read.
- out_valid never deasserts without a handshake, except on abort or reset.

Test Plan:
- Full buffer with wrap: DEPTH=10, RAM[i]=20+i, wr_ptr=3, fill_count=10, out_ready=1, pulse start -> out_data sequence 23,24,...,29,20,21,22. out_last only on 22. done pulses 31 cycles after start.
- Partial fill: fill_count=4, wr_ptr=4, RAM[0..3]=50,51,52,53 -> streams 50,51,52,53. rd_addr never exceeds 3. out_last on 53.
- Empty: fill_count=0, start -> no rd_en, no out_valid. done pulses 1 cycle after start. busy high for exactly 1 cycle.
- Backpressure: out_ready held low 5 cycles while out_valid=1 -> out_data/out_last stable, no new rd_en. Release -> next sample issued. Sequence unchanged.
- Abort and ignored start: abort during the 2nd PRESENT -> IDLE next cycle, no done. A start pulse during busy produces no extra samples.
- Reset mid-dump: assert rst in CAPTURE -> all outputs 0 immediately (async). A fresh start after release replays from the oldest sample.
